// File: rtl/level_table_param.sv
// level_table_param: per-user level table for the Memory-Tester game.
// Loads a user's level and best level at login. Promotes the level after
// WINS_PER_LEVEL wins and demotes it after LOSS_LIMIT consecutive losses.
// Writes both values back at logout for registered (green) users only.
//
// Ports:
//   clock          system clock, rising edge
//   rst            synchronous active-high reset
//   auth_bit       login request (sampled in IDLE)
//   internal_id    user ID, sampled with auth_bit
//   green_user     registered user flag, sampled with auth_bit
//   win / lose     round result pulses
//   rng_button     new-sequence request, clears the streak counters
//   log_out        end-of-session pulse
//   level_num      current session level, 0 when no session
//   best_level     best level of the current user, 0 when no session
//   levelupdated   1-cycle pulse on every level change
//   session_active high while in ACTIVE
//   max_reached    high while level_num == MAX_LEVEL in a session
module level_table_param #(
  parameter int unsigned NUM_USERS      = 8,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned LEVEL_W        = 4,
  parameter int unsigned START_LEVEL    = 1,
  parameter int unsigned MAX_LEVEL      = 15,
  parameter int unsigned WINS_PER_LEVEL = 2,
  parameter int unsigned LOSS_LIMIT     = 3
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               auth_bit,
  input  logic [ID_W-1:0]    internal_id,
  input  logic               green_user,
  input  logic               win,
  input  logic               lose,
  input  logic               rng_button,
  input  logic               log_out,
  output logic [LEVEL_W-1:0] level_num,
  output logic [LEVEL_W-1:0] best_level,
  output logic               levelupdated,
  output logic               session_active,
  output logic               max_reached
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
  localparam logic [1:0] StStore  = 2'd3;

  localparam int unsigned WinCntW  = $clog2(WINS_PER_LEVEL + 1);
  localparam int unsigned LossCntW = $clog2(LOSS_LIMIT + 1);

  localparam logic [LEVEL_W-1:0]  StartLvl = LEVEL_W'(START_LEVEL);
  localparam logic [LEVEL_W-1:0]  MaxLvl   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0]  ZeroLvl  = '0;
  localparam logic [WinCntW-1:0]  WinLast  = WinCntW'(WINS_PER_LEVEL - 1);
  localparam logic [LossCntW-1:0] LossLast = LossCntW'(LOSS_LIMIT - 1);

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                green_q, green_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LEVEL_W-1:0]  best_q, best_d;
  logic [WinCntW-1:0]  win_cnt_q, win_cnt_d;
  logic [LossCntW-1:0] loss_cnt_q, loss_cnt_d;
  logic                upd_q, upd_d;
  logic                active_q, active_d;
  logic                max_q, max_d;
  logic                wr_en;
  logic                guest;

  logic [LEVEL_W-1:0] lvl_tab_q  [NUM_USERS];
  logic [LEVEL_W-1:0] best_tab_q [NUM_USERS];

  // IDs beyond the table are guests: they start fresh and never write back.
  assign guest = (32'(id_q) >= NUM_USERS);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    green_d    = green_q;
    level_d    = level_q;
    best_d     = best_q;
    win_cnt_d  = win_cnt_q;
    loss_cnt_d = loss_cnt_q;
    upd_d      = 1'b0;
    active_d   = active_q;
    max_d      = max_q;
    wr_en      = 1'b0;

    case (state_q)
      StIdle: begin
        level_d    = ZeroLvl;
        best_d     = ZeroLvl;
        active_d   = 1'b0;
        max_d      = 1'b0;
        win_cnt_d  = '0;
        loss_cnt_d = '0;
        if (auth_bit) begin
          id_d    = internal_id;
          green_d = green_user;
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (guest) begin
          green_d = 1'b0;
          level_d = StartLvl;
          best_d  = StartLvl;
        end else begin
          level_d = lvl_tab_q[id_q];
          best_d  = best_tab_q[id_q];
        end
        active_d = 1'b1;
        max_d    = (level_d == MaxLvl);
        state_d  = StActive;
      end

      StActive: begin
        if (log_out) begin
          active_d = 1'b0;
          state_d  = StStore;
        end else if (win && lose) begin
          // Contradictory result: drop both.
        end else if (rng_button) begin
          win_cnt_d  = '0;
          loss_cnt_d = '0;
        end else if (win) begin
          loss_cnt_d = '0;
          if (win_cnt_q == WinLast) begin
            win_cnt_d = '0;
            if (level_q < MaxLvl) begin
              level_d = level_q + LEVEL_W'(1);
              upd_d   = 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + WinCntW'(1);
          end
        end else if (lose) begin
          win_cnt_d = '0;
          if (loss_cnt_q == LossLast) begin
            loss_cnt_d = '0;
            if (level_q > StartLvl) begin
              level_d = level_q - LEVEL_W'(1);
              upd_d   = 1'b1;
            end
          end else begin
            loss_cnt_d = loss_cnt_q + LossCntW'(1);
          end
        end
        // Best level follows the live maximum so STORE can write it directly.
        best_d = (level_d > best_q) ? level_d : best_q;
        max_d  = (level_d == MaxLvl);
      end

      StStore: begin
        wr_en      = green_q;
        level_d    = ZeroLvl;
        best_d     = ZeroLvl;
        active_d   = 1'b0;
        max_d      = 1'b0;
        win_cnt_d  = '0;
        loss_cnt_d = '0;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= StIdle;
      id_q       <= '0;
      green_q    <= 1'b0;
      level_q    <= ZeroLvl;
      best_q     <= ZeroLvl;
      win_cnt_q  <= '0;
      loss_cnt_q <= '0;
      upd_q      <= 1'b0;
      active_q   <= 1'b0;
      max_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      green_q    <= green_d;
      level_q    <= level_d;
      best_q     <= best_d;
      win_cnt_q  <= win_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      upd_q      <= upd_d;
      active_q   <= active_d;
      max_q      <= max_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_USERS; i++) begin
        lvl_tab_q[i]  <= StartLvl;
        best_tab_q[i] <= StartLvl;
      end
    end else if (wr_en) begin
      lvl_tab_q[id_q]  <= level_q;
      best_tab_q[id_q] <= best_q;
    end
  end

  assign level_num      = level_q;
  assign best_level     = best_q;
  assign levelupdated   = upd_q;
  assign session_active = active_q;
  assign max_reached    = max_q;

endmodule

// File: tb/tb_level_table_param.sv
module tb_level_table_param;

  logic       clock;
  logic       rst;
  logic       auth_bit;
  logic [2:0] internal_id;
  logic       green_user;
  logic       win;
  logic       lose;
  logic       rng_button;
  logic       log_out;
  logic [3:0] level_num;
  logic [3:0] best_level;
  logic       levelupdated;
  logic       session_active;
  logic       max_reached;

  level_table_param dut (
    .clock          (clock),
    .rst            (rst),
    .auth_bit       (auth_bit),
    .internal_id    (internal_id),
    .green_user     (green_user),
    .win            (win),
    .lose           (lose),
    .rng_button     (rng_button),
    .log_out        (log_out),
    .level_num      (level_num),
    .best_level     (best_level),
    .levelupdated   (levelupdated),
    .session_active (session_active),
    .max_reached    (max_reached)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected new level for every levelupdated pulse, in order.
  int upd_exp[$];
  // Expected level / best level at each session start, in order.
  int login_lvl_exp[$];
  int login_best_exp[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pulses and session starts are popped against the queues.
  logic prev_active = 1'b0;
  always @(negedge clock) begin
    if (levelupdated === 1'b1) begin
      if (upd_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at level %0d, expected none", level_num);
      end else begin
        check("pulse_level", int'(level_num), upd_exp.pop_front());
      end
    end
    if (session_active === 1'b1 && prev_active !== 1'b1) begin
      if (login_lvl_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_login: got level %0d, expected no session", level_num);
      end else begin
        check("login_level", int'(level_num), login_lvl_exp.pop_front());
        check("login_best", int'(best_level), login_best_exp.pop_front());
      end
    end
    prev_active = session_active;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One cycle of game inputs; promo != 0 expects a pulse to that level.
  task automatic drive(input logic w, input logic l, input logic r, input logic o,
                       input int promo);
    if (promo != 0) upd_exp.push_back(promo);
    win = w; lose = l; rng_button = r; log_out = o;
    cyc();
    win = 1'b0; lose = 1'b0; rng_button = 1'b0; log_out = 1'b0;
  endtask

  task automatic do_win(input int promo);
    drive(1'b1, 1'b0, 1'b0, 1'b0, promo);
  endtask

  task automatic do_lose(input int promo);
    drive(1'b0, 1'b1, 1'b0, 1'b0, promo);
  endtask

  task automatic login(input int id, input logic green, input int lvl, input int best);
    login_lvl_exp.push_back(lvl);
    login_best_exp.push_back(best);
    auth_bit = 1'b1; internal_id = 3'(id); green_user = green;
    cyc();
    auth_bit = 1'b0;
    cyc();
  endtask

  task automatic logout();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cyc();
    check("logout_level", int'(level_num), 0);
    check("logout_active", int'(session_active), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; auth_bit = 1'b0; internal_id = '0; green_user = 1'b0;
    win = 1'b0; lose = 1'b0; rng_button = 1'b0; log_out = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_level", int'(level_num), 0);
    check("rst_best", int'(best_level), 0);
    check("rst_upd", int'(levelupdated), 0);
    check("rst_active", int'(session_active), 0);
    check("rst_max", int'(max_reached), 0);

    // Persistence
    login(1, 1'b1, 1, 1);
    check("p_active", int'(session_active), 1);
    do_win(0);
    do_win(2);
    logout();
    login(1, 1'b1, 2, 2);
    logout();

    // Guest session discards progress
    login(2, 1'b0, 1, 1);
    do_win(0); do_win(2); do_win(0); do_win(3);
    check("guest_level", int'(level_num), 3);
    logout();
    login(2, 1'b1, 1, 1);
    logout();

    // green_user dropped mid-session is ignored
    login(3, 1'b1, 1, 1);
    green_user = 1'b0;
    do_win(0); do_win(2);
    logout();
    login(3, 1'b1, 2, 2);
    logout();

    // Demotion and floor
    login(4, 1'b1, 1, 1);
    do_win(0); do_win(2); do_win(0); do_win(3);
    do_lose(0); do_lose(0); do_lose(2);
    do_win(0);
    do_lose(0); do_lose(0); do_lose(1);
    do_lose(0); do_lose(0); do_lose(0);
    check("floor_level", int'(level_num), 1);
    check("floor_best", int'(best_level), 3);
    logout();
    login(4, 1'b1, 1, 3);
    logout();

    // Saturation
    login(5, 1'b1, 1, 1);
    for (int lv = 2; lv <= 14; lv++) begin
      do_win(0);
      do_win(lv);
    end
    check("pre_max", int'(max_reached), 0);
    do_win(0); do_win(15);
    check("max_flag", int'(max_reached), 1);
    do_win(0); do_win(0);
    check("sat_level", int'(level_num), 15);
    check("sat_best", int'(best_level), 15);
    logout();
    check("max_cleared", int'(max_reached), 0);

    // rng_button clears the win streak
    login(6, 1'b1, 1, 1);
    for (int lv = 2; lv <= 5; lv++) begin
      do_win(0);
      do_win(lv);
    end
    do_win(0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_win(0);
    check("rng_level", int'(level_num), 5);
    do_win(6);
    logout();

    // Simultaneous events
    login(7, 1'b1, 1, 1);
    do_win(0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_win(2);
    do_win(0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0);
    cyc();
    check("wl_logout_level", int'(level_num), 0);
    login(7, 1'b1, 2, 2);
    logout();
    login(1, 1'b1, 2, 2);
    do_win(0); do_win(3);
    logout();
    login(7, 1'b1, 2, 2);
    logout();

    // Reset mid-session
    login(0, 1'b1, 1, 1);
    do_win(0); do_win(2); do_win(0); do_win(3); do_win(0); do_win(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_level", int'(level_num), 0);
    check("mrst_best", int'(best_level), 0);
    check("mrst_active", int'(session_active), 0);
    check("mrst_upd", int'(levelupdated), 0);
    login(0, 1'b1, 1, 1);
    logout();
    login(1, 1'b1, 1, 1);
    logout();

    cyc(); cyc(); cyc();
    check("pending_pulses", upd_exp.size(), 0);
    check("pending_logins", login_lvl_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/level_table_param.md
Name: level_table_param

Overview:
- Parametrised per-user level table for the Memory-Tester game; successor to the fixed 8-user level table.
- Holds a persistent level and best level per user ID, loaded at login and written back at logout.
- Adds configurable wins-per-level promotion, loss-streak demotion, level saturation and a best-level record.
- Sits between the authentication block (auth_bit, internal_id, green_user) and the game core (win, lose, rng_button); drives level_num to the sequence generator.

Parameters:
- NUM_USERS, 8, number of table entries (IDs 0..NUM_USERS-1)
- ID_W, 3, width of internal_id
- LEVEL_W, 4, width of level values
- START_LEVEL, 1, level after reset, and the demotion floor
- MAX_LEVEL, 15, saturation ceiling; must satisfy START_LEVEL <= MAX_LEVEL <= 2^LEVEL_W-1
- WINS_PER_LEVEL, 2, wins needed per promotion (>=1)
- LOSS_LIMIT, 3, consecutive losses needed per demotion (>=1)

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- auth_bit  in  1  login request; level, sampled in IDLE
- internal_id  in  ID_W  user ID, sampled with auth_bit
- green_user  in  1  registered user (progress saved), sampled with auth_bit
- win  in  1  round won, 1-cycle pulse
- lose  in  1  round lost, 1-cycle pulse
- rng_button  in  1  new-sequence request; clears streak counters
- log_out  in  1  end of session, pulse
- level_num  out  LEVEL_W  current session level; 0 when no session
- best_level  out  LEVEL_W  best level stored for the current user; 0 when no session
- levelupdated  out  1  1-cycle pulse on every level change
- session_active  out  1  high in ACTIVE state
- max_reached  out  1  high while level_num == MAX_LEVEL in a session

Behaviour:
- Reset: all outputs 0, FSM to IDLE, every table entry and best entry = START_LEVEL, win_cnt = loss_cnt = 0. Reset mid-session discards the session and does not write back.
- All outputs are registered.
- FSM states: IDLE -> LOAD -> ACTIVE -> STORE -> IDLE.
- IDLE:
  - auth_bit=1 latches internal_id into id_q and green_user into green_q, then moves to LOAD.
  - win, lose, rng_button and log_out are ignored.
- LOAD (1 cycle):
  - Working level = table[id_q]; level_num and best_level take the entry values on the exit edge.
  - session_active = 1 from the first ACTIVE cycle.
  - No levelupdated pulse.
  - If id_q >= NUM_USERS, the session is a guest: green_q is forced to 0 and the session level is START_LEVEL.
- ACTIVE, priority order per edge:
  - rst
  - log_out -> STORE. Any win, lose or rng_button in the same cycle is dropped.
  - win and lose together -> both ignored.
  - rng_button -> win_cnt = loss_cnt = 0. A win or lose in the same cycle is ignored.
  - win:
    - loss_cnt = 0 and win_cnt is incremented.
    - When win_cnt reaches WINS_PER_LEVEL: win_cnt = 0; if level < MAX_LEVEL, level+1 and levelupdated = 1 on the same edge.
    - At MAX_LEVEL: level is unchanged and there is no pulse.
  - lose:
    - win_cnt = 0 and loss_cnt is incremented.
    - When loss_cnt reaches LOSS_LIMIT: loss_cnt = 0; if level > START_LEVEL, level-1 with a pulse.
    - At the floor: level is unchanged and there is no pulse.
- Best level:
  - best_level tracks max(best, level) live during ACTIVE.
  - Table updates happen only in STORE.
- Timing: level_num and levelupdated change on the same edge that samples the qualifying win or lose, i.e. they are visible the cycle after the pulse. levelupdated is high for exactly one cycle.
- Input changes mid-session: changes of auth_bit, internal_id or green_user during LOAD, ACTIVE or STORE are ignored.
- STORE (1 cycle):
  - If green_q = 1: table[id_q] = level, best[id_q] = max(best, level).
  - Guests write nothing.
  - Then IDLE: level_num = best_level = 0, session_active = 0, counters cleared.
- Re-login: auth_bit still high in IDLE after STORE starts a new login on the next edge.
- Counter widths: win_cnt and loss_cnt are sized to clog2 of their limit +1. Level arithmetic never wraps.

Test Plan:
- Persistence: rst; login id=1, green=1 -> level_num=1, session_active=1. Win, win -> level_num=2 with a single levelupdated pulse. log_out -> level_num=0. Re-login id=1 -> level_num=2, best_level=2.
- Guest discard and green_user drop:
  - Login id=2, green=0; 4 wins -> level_num=3; log_out. Re-login id=2 green -> level_num=1.
  - Login id=3, green=1, drop green mid-session; 2 wins; log_out. Re-login -> level_num=2.
- Demotion and floor:
  - From level 3, 3 loses -> level 2 with a pulse.
  - Win, lose, lose, lose -> level 1.
  - 3 more loses at level 1 -> level_num=1, no pulse.
  - best_level stays 3 after logout and re-login.
- Saturation and rng: reach MAX_LEVEL=15 -> max_reached=1; 2 further wins -> no pulse, level 15. Win, rng_button, win at level 5 -> no promotion.
- Simultaneous events:
  - win and lose in the same cycle -> no counter change.
  - Second win coinciding with log_out -> dropped; stored level unchanged.
  - id=7 entry unaffected by id=1 activity.
- Reset mid-session: level 4 in ACTIVE, assert rst one cycle -> all outputs 0, IDLE. Re-login -> level_num=1 (no write-back).
